// File: rtl/pwm_pkg.sv
// Shared types and helpers for the sign/magnitude PWM block.
package pwm_pkg;

  localparam int DIVIDER_DEF = 255;
  localparam int PERIOD      = DIVIDER_DEF + 1;

  typedef enum logic {
    RUN  = 1'b0,
    DEAD = 1'b1
  } pwm_ch_state_e;

  // Works on a 64-bit sign-extended duty so the most negative input cannot overflow.
  function automatic logic [63:0] sat_abs(input logic signed [63:0] v, input logic [63:0] max);
    logic [63:0] m;
    m = v[63] ? -v : v;
    return (m > max) ? max : m;
  endfunction

endpackage

// File: rtl/vout_pwm_chan.sv
// One PWM/dir channel: boundary sampling with saturation, registered compare, optional
// direction-change dead time (DIR_DEADTIME_EN).
module vout_pwm_chan
  import pwm_pkg::*;
#(
  parameter int DTY_W   = 32,
  parameter int CNT_W   = 16,
  parameter int DIVIDER = 255
`ifdef DIR_DEADTIME_EN
  ,
  parameter int DEADTIME = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             bnd_i,
  input  logic [DTY_W-1:0] dty_i,
  input  logic             disabled_i,
  output logic             dir_o,
  output logic             pwm_o
);

  localparam int MAG_W = CNT_W + 1;

  logic [MAG_W-1:0]  mag_q, mag_d;
  logic              dir_q, dir_d;
  logic              pwm_q;
  logic signed [63:0] dty_sx;
  logic              hit;

  assign dty_sx = {{(64 - DTY_W){dty_i[DTY_W-1]}}, dty_i};
  assign mag_d  = MAG_W'(sat_abs(dty_sx, 64'(DIVIDER + 1)));
  assign dir_d  = !dty_i[DTY_W-1] && (dty_i != '0);
  assign hit    = ({1'b0, cnt_i} < mag_q) && !disabled_i;

`ifdef DIR_DEADTIME_EN
  localparam int DW = (DEADTIME > 0) ? $clog2(DEADTIME + 1) : 1;

  pwm_ch_state_e state_q;
  logic [DW-1:0] dead_q;
  logic          flip;

  assign flip = bnd_i && (dir_d != dir_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_q   <= '0;
      dir_q   <= 1'b0;
      pwm_q   <= 1'b0;
      state_q <= RUN;
      dead_q  <= '0;
    end else begin
      // The boundary cycle of a sign change is already blanked, before dir toggles.
      pwm_q <= hit && !flip && (state_q == RUN);
      if (bnd_i) begin
        mag_q <= mag_d;
        dir_q <= dir_d;
        if (flip) begin
          state_q <= (DEADTIME > 0) ? DEAD : RUN;
          dead_q  <= DW'(DEADTIME);
        end else begin
          state_q <= RUN;
          dead_q  <= '0;
        end
      end else if (state_q == DEAD) begin
        if (dead_q == DW'(1)) state_q <= RUN;
        dead_q <= dead_q - DW'(1);
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_q <= '0;
      dir_q <= 1'b0;
      pwm_q <= 1'b0;
    end else begin
      pwm_q <= hit;
      if (bnd_i) begin
        mag_q <= mag_d;
        dir_q <= dir_d;
      end
    end
  end
`endif

  assign dir_o = dir_q;
  assign pwm_o = pwm_q;

endmodule

// File: rtl/vout_pwm_multi.sv
// N-channel sign/magnitude PWM with a shared period counter and period_start strobe.
// DIR_DEADTIME_EN enables per-channel direction-change dead time.
module vout_pwm_multi
  import pwm_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int DTY_W    = 32,
  parameter int CNT_W    = 16,
  parameter int DIVIDER  = PERIOD - 1,
  parameter int DEADTIME = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*DTY_W-1:0] dty,
  input  logic [CHANNELS-1:0]       disabled,
  output logic                      period_start,
  output logic [CHANNELS-1:0]       dir,
  output logic [CHANNELS-1:0]       pwm
);

  if (CHANNELS < 1 || CHANNELS > 16 || DTY_W < 2 || DTY_W > 63 || DIVIDER < 0 ||
      64'(DIVIDER) >= (64'd1 << CNT_W) || DEADTIME < 0) begin : g_bad_cfg
    $error("vout_pwm_multi: illegal parameter set");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             init_q;
  logic             ps_q;
  logic             bnd;

  // The cycle right after reset release acts as a boundary so the first period starts at once.
  assign bnd   = init_q || (cnt_q == CNT_W'(DIVIDER));
  assign cnt_d = bnd ? '0 : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      init_q <= 1'b1;
      ps_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      init_q <= 1'b0;
      ps_q   <= bnd;
    end
  end

  assign period_start = ps_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    vout_pwm_chan #(
      .DTY_W   (DTY_W),
      .CNT_W   (CNT_W),
      .DIVIDER (DIVIDER)
`ifdef DIR_DEADTIME_EN
      ,
      .DEADTIME(DEADTIME)
`endif
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .cnt_i     (cnt_q),
      .bnd_i     (bnd),
      .dty_i     (dty[g*DTY_W +: DTY_W]),
      .disabled_i(disabled[g]),
      .dir_o     (dir[g]),
      .pwm_o     (pwm[g])
    );
  end

endmodule

// File: tb/tb_vout_pwm_multi.sv
// Bench for vout_pwm_multi: period-level reference model plus directed literal expectations.
module tb_vout_pwm_multi;

  localparam int CH = 4, DW = 32, CW = 8, DIV = 9, DT = 3;
  localparam int PERIOD = DIV + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [CH*DW-1:0]  dty;
  logic [CH-1:0]     disabled;
  logic              period_start;
  logic [CH-1:0]     dir, pwm;

  int n_vec = 0, n_bad = 0;

  // Reference model: position in the period and the per-channel magnitude/sign in effect.
  int          ph;
  bit          first;
  int          mmag [CH];
  bit          mdir [CH];
  bit          mdead[CH];
  logic        exp_ps;
  logic [CH-1:0] exp_dir, exp_pwm;
  logic [31:0] bits;

  always #5 clk = ~clk;

  vout_pwm_multi #(
    .CHANNELS(CH), .DTY_W(DW), .CNT_W(CW), .DIVIDER(DIV), .DEADTIME(DT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .dty(dty), .disabled(disabled),
    .period_start(period_start), .dir(dir), .pwm(pwm)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ph = 0;
    first = 1'b1;
    for (int i = 0; i < CH; i++) begin
      mmag[i] = 0; mdir[i] = 1'b0; mdead[i] = 1'b0;
    end
    exp_ps = 1'b0; exp_dir = '0; exp_pwm = '0;
  endtask

  // Outputs expected after the coming clock edge, from this cycle's position and inputs.
  task automatic model_step();
    bit bnd, nd, flip, p;
    logic signed [DW-1:0] s;
    longint d, a;
    int nm;
    bnd = first || (ph == DIV);
    for (int i = 0; i < CH; i++) begin
      s  = dty[i*DW +: DW];
      d  = s;
      a  = (d < 0) ? -d : d;
      nm = (a > PERIOD) ? PERIOD : int'(a);
      nd = (d > 0);
      flip = bnd && (nd != mdir[i]);
      p = (ph < mmag[i]) && !disabled[i];
`ifdef DIR_DEADTIME_EN
      if (flip || (mdead[i] && ph < DT)) p = 1'b0;
`endif
      exp_pwm[i] = p;
      if (bnd) begin
        mmag[i] = nm;
        mdir[i] = nd;
`ifdef DIR_DEADTIME_EN
        mdead[i] = flip;
`else
        mdead[i] = 1'b0;
`endif
      end
      exp_dir[i] = mdir[i];
    end
    exp_ps = bnd;
    ph     = bnd ? 0 : ph + 1;
    first  = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst_n) model_reset();
    chk("period_start", 32'(period_start), 32'(exp_ps));
    chk("dir", 32'(dir), 32'(exp_dir));
    chk("pwm", 32'(pwm), 32'(exp_pwm));
    if (rst_n) model_step();
  end

  task automatic set_dty(input int ch, input logic [31:0] v);
    dty[ch*DW +: DW] = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_phase(input int k);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (ph != k && n < 4 * PERIOD);
    if (ph != k) begin
      n_vec++;
      n_bad++;
      $display("FAIL goto_phase: phase %0d not reached, at %0d", k, ph);
    end
  endtask

  task automatic window(input int ch, input int n, output logic [31:0] b);
    b = '0;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      b[j] = pwm[ch];
      tick();
    end
  endtask

  function automatic logic [31:0] rnd_duty();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'd0;
      1:       v = 32'($urandom_range(1, 12));
      2:       begin v = 32'($urandom_range(1, 12)); v = ~v + 32'd1; end
      3:       v = 32'h8000_0000;
      4:       v = 32'h7FFF_FFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    int ch;
    rst_n = 1'b0;
    dty = '0;
    disabled = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // +3 on ch0: dir=1, high in cycles 1..3 of every period
    set_dty(0, 32'd3);
    goto_phase(0); goto_phase(0);
    chk("t1_dir0", 32'(dir[0]), 32'd1);
    window(0, 10, bits);
    chk("t1_pwm0", bits, 32'h0000_000E);

    // -4, then most negative (saturates), then zero on ch1
    set_dty(1, 32'hFFFF_FFFC);
    goto_phase(0);
    chk("t2_dir1_neg", 32'(dir[1]), 32'd0);
    window(1, 10, bits);
    chk("t2_pwm1_neg4", bits, 32'h0000_001E);
    set_dty(1, 32'h8000_0000);
    goto_phase(0); goto_phase(0);
    window(1, 10, bits);
    chk("t2_pwm1_sat", bits, 32'h0000_03FF);
    chk("t2_dir1_sat", 32'(dir[1]), 32'd0);
    set_dty(1, 32'd0);
    goto_phase(0); goto_phase(0);
    window(1, 10, bits);
    chk("t2_pwm1_zero", bits, 32'd0);
    chk("t2_dir1_zero", 32'(dir[1]), 32'd0);

    // duty change 2 -> 7 mid-period on ch2 only takes effect next period
    set_dty(2, 32'd2);
    goto_phase(0); goto_phase(0);
    bits = '0;
    for (int j = 0; j < 20; j++) begin
      if (j == 4) set_dty(2, 32'd7);
      @(negedge clk);
      bits[j] = pwm[2];
      tick();
    end
    chk("t3_pwm2", bits, 32'h0003_F806);

    // disabled pulse at cnt 1 for 2 cycles on ch3 with duty 8
    set_dty(3, 32'd8);
    goto_phase(0); goto_phase(0);
    bits = '0;
    for (int j = 0; j < 10; j++) begin
      if (j == 1) disabled[3] = 1'b1;
      if (j == 3) disabled[3] = 1'b0;
      @(negedge clk);
      bits[j] = pwm[3];
      tick();
    end
    chk("t4_pwm3", bits, 32'h0000_01F2);
    chk("t4_dir3", 32'(dir[3]), 32'd1);

    // async reset mid-period while pwm is high
    goto_phase(5);
    chk("t5_pwm3_pre", 32'(pwm[3]), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_pwm_rst", 32'(pwm), 32'd0);
    chk("t5_dir_rst", 32'(dir), 32'd0);
    chk("t5_ps_rst", 32'(period_start), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("t5_ps_release", 32'(period_start), 32'd0);
    tick();
    chk("t5_ps_first", 32'(period_start), 32'd1);

    // sign change +6 -> -6 on ch0
    set_dty(0, 32'd6);
    goto_phase(0); goto_phase(0); goto_phase(0);
    goto_phase(5);
    set_dty(0, 32'hFFFF_FFFA);
    goto_phase(0);
    chk("t6_dir0", 32'(dir[0]), 32'd0);
    window(0, 10, bits);
`ifdef DIR_DEADTIME_EN
    chk("t6_pwm0_dead", bits, 32'h0000_0070);
`else
    chk("t6_pwm0", bits, 32'h0000_007E);
`endif

    // randomized duties, disables and one reset
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        ch = int'($urandom_range(0, CH - 1));
        set_dty(ch, rnd_duty());
      end
      if ($urandom_range(0, 9) == 0) begin
        ch = int'($urandom_range(0, CH - 1));
        disabled[ch] = ~disabled[ch];
      end
      if (c == 700) begin
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
      end
      tick();
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
